// File: rtl/miss_req_sched.sv
// Retransmit request scheduler: queues sequence-number gaps per session and issues
// rate-limited retransmit requests, splitting large gaps into REQ_CNT_MAX chunks.
//
// state | meaning
// IDLE  | no request outstanding, waiting for a queued gap
// SEND  | request for the queue head presented, held until accepted
// GAP   | enforced idle spacing after an accepted request
module miss_req_sched #(
    parameter int SEQ_NUM_W   = 64,
    parameter int SID_W       = 80,
    parameter int ML_W        = 16,
    parameter int DEPTH       = 4,
    parameter int REQ_CNT_MAX = 255,
    parameter int GAP_CYC     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss_seq_num_v_i,
    input  logic [SID_W-1:0]         miss_seq_num_sid_i,
    input  logic [SEQ_NUM_W-1:0]     miss_seq_num_start_i,
    input  logic [SEQ_NUM_W-1:0]     miss_seq_num_cnt_i,
    input  logic                     miss_sid_v_i,
    output logic                     req_v_o,
    input  logic                     req_ready_i,
    output logic [SID_W-1:0]         req_sid_o,
    output logic [SEQ_NUM_W-1:0]     req_seq_num_o,
    output logic [ML_W-1:0]          req_cnt_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic                     overflow_o,
    output logic [7:0]               sid_miss_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [SEQ_NUM_W-1:0] MAX_SEQ  = SEQ_NUM_W'(REQ_CNT_MAX);
    localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(GAP_CYC);
    localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [SID_W-1:0]     sid_mem_q   [DEPTH];
    logic [SEQ_NUM_W-1:0] start_mem_q [DEPTH];
    logic [SEQ_NUM_W-1:0] cnt_mem_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [7:0]       sid_miss_q;
    logic             overflow_q;
    logic             req_v_q;
    state_t           state_q;

    logic [SID_W-1:0]     head_sid;
    logic [SEQ_NUM_W-1:0] head_start, head_cnt;
    logic head_big, accept, pop, full, gap_valid, push, drop;

    always_comb begin
        head_sid   = sid_mem_q[rd_ptr_q];
        head_start = start_mem_q[rd_ptr_q];
        head_cnt   = cnt_mem_q[rd_ptr_q];
        head_big   = head_cnt > MAX_SEQ;
        accept     = (state_q == SEND) && req_ready_i;
        pop        = accept && !head_big;
        full       = (count_q == FULL_CNT);
        gap_valid  = miss_seq_num_v_i && (miss_seq_num_cnt_i != '0);
        // A pop in the same cycle frees the slot, so a full queue can still accept.
        push       = gap_valid && (!full || pop);
        drop       = gap_valid && full && !pop;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sid_mem_q[i]   <= '0;
                start_mem_q[i] <= '0;
                cnt_mem_q[i]   <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            gap_cnt_q  <= '0;
            sid_miss_q <= '0;
            overflow_q <= 1'b0;
            req_v_q    <= 1'b0;
            state_q    <= IDLE;
        end else begin
            if (push) begin
                sid_mem_q[wr_ptr_q]   <= miss_seq_num_sid_i;
                start_mem_q[wr_ptr_q] <= miss_seq_num_start_i;
                cnt_mem_q[wr_ptr_q]   <= miss_seq_num_cnt_i;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end else if (accept) begin
                // Oversized gap: the head stays queued and advances by one chunk.
                start_mem_q[rd_ptr_q] <= head_start + MAX_SEQ;
                cnt_mem_q[rd_ptr_q]   <= head_cnt - MAX_SEQ;
            end
            count_q <= count_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (miss_sid_v_i && (sid_miss_q != 8'hFF)) begin
                sid_miss_q <= sid_miss_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (count_d != '0) begin
                        state_q <= SEND;
                        req_v_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (req_ready_i) begin
                        state_q   <= GAP;
                        req_v_q   <= 1'b0;
                        gap_cnt_q <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt_q <= GAP_W'(1)) begin
                        gap_cnt_q <= '0;
                        if (count_d != '0) begin
                            state_q <= SEND;
                            req_v_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_v_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_v_o        = req_v_q;
    assign req_sid_o      = head_sid;
    assign req_seq_num_o  = head_start;
    assign req_cnt_o      = head_big ? ML_W'(REQ_CNT_MAX) : ML_W'(head_cnt);
    assign pending_o      = count_q;
    assign overflow_o     = overflow_q;
    assign sid_miss_cnt_o = sid_miss_q;

endmodule
